ddr4_avmm_bank_model: RTL and testbench

- Avalon-MM responder modelling one DDR4 bank: the slave end of the AFU's DDR4a/DDR4b master ports.
- Used in SIM_MODE builds and loopback self-test in place of the EMIF controller.
- Accepts burst writes and pipelined burst reads against an internal line-wide RAM.
- Returns read data in order, with a fixed minimum latency.

---
 rtl/ddr4_avmm_bank_model_if.sv | 45 ++++
 rtl/ddr4_avmm_bank_model.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_ddr4_avmm_bank_model.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_avmm_bank_model_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr4_avmm_bank_model_if
// Description : Avalon-MM bus bundle between an AFU DDR4 master port and the
//               single-bank DDR4 responder model.
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr4_avmm_bank_model_if #(
    parameter int ADDR_WIDTH = 27
) ();
    logic                  DDR4_waitrequest;
    logic [511:0]          DDR4_readdata;
    logic                  DDR4_readdatavalid;
    logic [6:0]            DDR4_burstcount;
    logic [511:0]          DDR4_writedata;
    logic [ADDR_WIDTH-1:0] DDR4_address;
    logic                  DDR4_write;
    logic                  DDR4_read;
    logic [63:0]           DDR4_byteenable;

    modport master (
        input  DDR4_waitrequest,
        input  DDR4_readdata,
        input  DDR4_readdatavalid,
        output DDR4_burstcount,
        output DDR4_writedata,
        output DDR4_address,
        output DDR4_write,
        output DDR4_read,
        output DDR4_byteenable
    );

    modport slave (
        output DDR4_waitrequest,
        output DDR4_readdata,
        output DDR4_readdatavalid,
        input  DDR4_burstcount,
        input  DDR4_writedata,
        input  DDR4_address,
        input  DDR4_write,
        input  DDR4_read,
        input  DDR4_byteenable
    );
endinterface
`default_nettype wire

// File: rtl/ddr4_avmm_bank_model.sv
`default_nettype none
// ============================================================================
// Module      : ddr4_avmm_bank_model
// Description : Avalon-MM responder modelling one DDR4 bank: burst writes,
//               pipelined in-order burst reads with fixed minimum latency.
//               Optional macro DDR4_MODEL_RANDOM_WAIT_EN adds LFSR stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr4_avmm_bank_model #(
    parameter int ADDR_WIDTH   = 27,
    parameter int MEM_AW       = 10,
    parameter int READ_LATENCY = 4,
    parameter int CMD_DEPTH    = 8
) (
    input  wire logic                           DDR4_USERCLK,
    input  wire logic                           DDR4_SoftReset_n,
    ddr4_avmm_bank_model_if.slave               avmm,
    output logic                                proto_err,
    output logic [$clog2(CMD_DEPTH+1)-1:0]      rd_outstanding
);

    localparam int c_PIPE_STAGES = READ_LATENCY - 2;
    localparam int c_OW          = $clog2(CMD_DEPTH + 1);
    localparam int c_QAW         = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int c_BW          = 7;
    localparam int c_CMD_W       = MEM_AW + c_BW;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WR_BURST = 1'b1
    } wr_state_t;

    wr_state_t             r_state;
    wr_state_t             w_state_nxt;
    logic [MEM_AW-1:0]     r_wr_addr;
    logic [MEM_AW-1:0]     w_wr_addr;
    logic [MEM_AW-1:0]     w_wr_addr_nxt;
    logic [c_BW-1:0]       r_wr_left;
    logic [c_BW-1:0]       w_wr_left_nxt;

    logic [511:0]          r_mem [2**MEM_AW];

    logic                  w_stall;
    logic                  w_rd_full;
    logic                  w_waitreq;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_bc_zero;
    logic [c_BW-1:0]       w_bc_norm;
    logic [MEM_AW-1:0]     w_addr_lo;
    logic [c_CMD_W-1:0]    w_cmd_in;
    logic                  w_proto_viol;
    logic                  r_proto_err;

    logic                  w_pipe_vld;
    logic [c_CMD_W-1:0]    w_pipe_cmd;

    logic [c_CMD_W-1:0]    r_q [CMD_DEPTH];
    logic [c_QAW-1:0]      r_q_wp;
    logic [c_QAW-1:0]      r_q_rp;
    logic [c_OW-1:0]       r_q_cnt;
    logic [c_CMD_W-1:0]    w_head;

    logic                  r_eng_busy;
    logic [MEM_AW-1:0]     r_eng_addr;
    logic [c_BW-1:0]       r_eng_left;
    logic                  w_issue;
    logic                  w_eng_pop;
    logic [MEM_AW-1:0]     w_iss_addr;
    logic [c_BW-1:0]       w_iss_left;

    logic [511:0]          r_rd_data;
    logic                  r_rdv;
    logic                  r_rdv_last;
    logic                  w_rd_done;
    logic [c_OW-1:0]       r_outstanding;

    // Upper line-address bits alias onto the RAM and are deliberately dropped.
    logic                  w_unused_addr_hi;
    assign w_unused_addr_hi = ^avmm.DDR4_address[ADDR_WIDTH-1:MEM_AW];

    assign w_addr_lo = avmm.DDR4_address[MEM_AW-1:0];
    assign w_bc_zero = (avmm.DDR4_burstcount == '0);
    assign w_bc_norm = w_bc_zero ? c_BW'(1) : avmm.DDR4_burstcount;
    assign w_cmd_in  = {w_addr_lo, w_bc_norm};

`ifdef DDR4_MODEL_RANDOM_WAIT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge DDR4_USERCLK or negedge DDR4_SoftReset_n) begin
        if (!DDR4_SoftReset_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // A concurrent write wins the bus, so the read term only stalls pure reads.
    assign w_rd_full = (r_outstanding == c_OW'(CMD_DEPTH));
    assign w_waitreq = !DDR4_SoftReset_n || w_stall ||
                       (avmm.DDR4_read && !avmm.DDR4_write &&
                        ((r_state == ST_WR_BURST) || w_rd_full));
    assign w_wr_acc  = avmm.DDR4_write && !w_waitreq;
    assign w_rd_acc  = avmm.DDR4_read && !avmm.DDR4_write && (r_state == ST_IDLE) &&
                       !w_rd_full && !w_waitreq;

    assign w_proto_viol = (avmm.DDR4_read && avmm.DDR4_write) ||
                          (w_wr_acc && (r_state == ST_IDLE) && w_bc_zero) ||
                          (w_rd_acc && w_bc_zero);

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_addr     = r_wr_addr;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_left_nxt = r_wr_left;
        unique case (r_state)
            ST_IDLE: begin
                if (w_wr_acc) begin
                    w_wr_addr     = w_addr_lo;
                    w_wr_addr_nxt = w_addr_lo + 1'b1;
                    w_wr_left_nxt = w_bc_norm - 1'b1;
                    if (w_bc_norm > c_BW'(1)) begin
                        w_state_nxt = ST_WR_BURST;
                    end
                end
            end
            ST_WR_BURST: begin
                if (w_wr_acc) begin
                    w_wr_addr_nxt = r_wr_addr + 1'b1;
                    w_wr_left_nxt = r_wr_left - 1'b1;
                    if (r_wr_left == c_BW'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge DDR4_USERCLK or negedge DDR4_SoftReset_n) begin
        if (!DDR4_SoftReset_n) begin
            r_state   <= ST_IDLE;
            r_wr_addr <= '0;
            r_wr_left <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_left <= w_wr_left_nxt;
        end
    end

    always_ff @(posedge DDR4_USERCLK) begin
        if (w_wr_acc) begin
            for (int i = 0; i < 64; i++) begin
                if (avmm.DDR4_byteenable[i]) begin
                    r_mem[w_wr_addr][i*8 +: 8] <= avmm.DDR4_writedata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge DDR4_USERCLK or negedge DDR4_SoftReset_n) begin
        if (!DDR4_SoftReset_n) begin
            r_proto_err <= 1'b0;
        end else if (w_proto_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    // Accepted read commands age here so the queue head appears at latency-1.
    generate
        if (c_PIPE_STAGES == 0) begin : g_no_pipe
            assign w_pipe_vld = w_rd_acc;
            assign w_pipe_cmd = w_cmd_in;
        end else begin : g_pipe
            logic [c_PIPE_STAGES-1:0] r_vld;
            logic [c_CMD_W-1:0]       r_cmd [c_PIPE_STAGES];

            always_ff @(posedge DDR4_USERCLK or negedge DDR4_SoftReset_n) begin
                if (!DDR4_SoftReset_n) begin
                    r_vld <= '0;
                    for (int i = 0; i < c_PIPE_STAGES; i++) begin
                        r_cmd[i] <= '0;
                    end
                end else begin
                    r_vld[0] <= w_rd_acc;
                    r_cmd[0] <= w_cmd_in;
                    for (int i = 1; i < c_PIPE_STAGES; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_cmd[i] <= r_cmd[i-1];
                    end
                end
            end

            assign w_pipe_vld = r_vld[c_PIPE_STAGES-1];
            assign w_pipe_cmd = r_cmd[c_PIPE_STAGES-1];
        end
    endgenerate

    function automatic logic [c_QAW-1:0] f_ptr_inc(input logic [c_QAW-1:0] p);
        return (p == c_QAW'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge DDR4_USERCLK) begin
        if (w_pipe_vld) begin
            r_q[r_q_wp] <= w_pipe_cmd;
        end
    end

    always_ff @(posedge DDR4_USERCLK or negedge DDR4_SoftReset_n) begin
        if (!DDR4_SoftReset_n) begin
            r_q_wp  <= '0;
            r_q_rp  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_pipe_vld) begin
                r_q_wp <= f_ptr_inc(r_q_wp);
            end
            if (w_eng_pop) begin
                r_q_rp <= f_ptr_inc(r_q_rp);
            end
            unique case ({w_pipe_vld, w_eng_pop})
                2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
                2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    assign w_head = r_q[r_q_rp];

    // The head is taken in the same cycle the previous burst ends, so bursts
    // queued behind each other stream without a bubble.
    always_comb begin
        w_issue    = 1'b0;
        w_eng_pop  = 1'b0;
        w_iss_addr = r_eng_addr;
        w_iss_left = r_eng_left;
        if (r_eng_busy) begin
            w_issue = 1'b1;
        end else if (r_q_cnt != '0) begin
            w_issue    = 1'b1;
            w_eng_pop  = 1'b1;
            w_iss_addr = w_head[c_CMD_W-1:c_BW];
            w_iss_left = w_head[c_BW-1:0];
        end
    end

    always_ff @(posedge DDR4_USERCLK or negedge DDR4_SoftReset_n) begin
        if (!DDR4_SoftReset_n) begin
            r_eng_busy <= 1'b0;
            r_eng_addr <= '0;
            r_eng_left <= '0;
            r_rd_data  <= '0;
            r_rdv      <= 1'b0;
            r_rdv_last <= 1'b0;
        end else begin
            r_rdv      <= w_issue;
            r_rdv_last <= w_issue && (w_iss_left <= c_BW'(1));
            if (w_issue) begin
                r_eng_busy <= (w_iss_left > c_BW'(1));
                r_eng_addr <= w_iss_addr + 1'b1;
                r_eng_left <= w_iss_left - 1'b1;
                r_rd_data  <= r_mem[w_iss_addr];
            end
        end
    end

    assign w_rd_done = r_rdv && r_rdv_last;

    always_ff @(posedge DDR4_USERCLK or negedge DDR4_SoftReset_n) begin
        if (!DDR4_SoftReset_n) begin
            r_outstanding <= '0;
        end else begin
            unique case ({w_rd_acc, w_rd_done})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign avmm.DDR4_waitrequest   = w_waitreq;
    assign avmm.DDR4_readdata      = r_rd_data;
    assign avmm.DDR4_readdatavalid = r_rdv;
    assign proto_err               = r_proto_err;
    assign rd_outstanding          = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_avmm_bank_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr4_avmm_bank_model
// Description : Scoreboard bench for ddr4_avmm_bank_model (latency 4 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr4_avmm_bank_model;

    localparam int L0 = 4;
    localparam int L1 = 16;

    typedef struct {
        logic [511:0] d;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [26:0]  b_addr = '0;
    logic [6:0]   b_bc = '0;
    logic [511:0] b_wdata = '0;
    logic [63:0]  b_be = '0;
    logic         b_rd = 1'b0;
    logic         b_wr = 1'b0;
    int           b_sel = 0;

    logic         perr0, perr1;
    logic [3:0]   out0, out1;

    ddr4_avmm_bank_model_if #(.ADDR_WIDTH(27)) if0 ();
    ddr4_avmm_bank_model_if #(.ADDR_WIDTH(27)) if1 ();

    assign if0.DDR4_address    = b_addr;
    assign if0.DDR4_burstcount = b_bc;
    assign if0.DDR4_writedata  = b_wdata;
    assign if0.DDR4_byteenable = b_be;
    assign if0.DDR4_read       = b_rd && (b_sel == 0);
    assign if0.DDR4_write      = b_wr && (b_sel == 0);
    assign if1.DDR4_address    = b_addr;
    assign if1.DDR4_burstcount = b_bc;
    assign if1.DDR4_writedata  = b_wdata;
    assign if1.DDR4_byteenable = b_be;
    assign if1.DDR4_read       = b_rd && (b_sel == 1);
    assign if1.DDR4_write      = b_wr && (b_sel == 1);

    ddr4_avmm_bank_model #(.ADDR_WIDTH(27), .MEM_AW(10), .READ_LATENCY(L0), .CMD_DEPTH(8)) u_dut0 (
        .DDR4_USERCLK     (clk),
        .DDR4_SoftReset_n (rst_n),
        .avmm             (if0.slave),
        .proto_err        (perr0),
        .rd_outstanding   (out0)
    );

    ddr4_avmm_bank_model #(.ADDR_WIDTH(27), .MEM_AW(10), .READ_LATENCY(L1), .CMD_DEPTH(8)) u_dut1 (
        .DDR4_USERCLK     (clk),
        .DDR4_SoftReset_n (rst_n),
        .avmm             (if1.slave),
        .proto_err        (perr1),
        .rd_outstanding   (out1)
    );

    logic [511:0] mdl [2][1024];
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int s);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = {16'(s), 16'(i)} ^ 32'h5A3C_0000;
        return v;
    endfunction

    // Monitor: every readdatavalid beat pops one expected entry.
    always @(negedge clk) begin
        if (if0.DDR4_readdatavalid) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_beat", 512'(1), 512'(0));
            end else begin
                e0 = q0.pop_front();
                chk("dut0_rdata", if0.DDR4_readdata, e0.d);
                if (e0.cyc >= 0) chk("dut0_latency_cycle", 512'(cyc), 512'(e0.cyc));
            end
        end
        if (if1.DDR4_readdatavalid) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_beat", 512'(1), 512'(0));
            end else begin
                e1 = q1.pop_front();
                chk("dut1_rdata", if1.DDR4_readdata, e1.d);
                if (e1.cyc >= 0) chk("dut1_latency_cycle", 512'(cyc), 512'(e1.cyc));
            end
        end
    end

    task automatic wait_acc(input string nm, output int acc, output bit ok);
        int  t = 0;
        logic wr;
        ok  = 1'b0;
        acc = 0;
        while (1) begin
            @(negedge clk);
            wr = (b_sel == 1) ? if1.DDR4_waitrequest : if0.DDR4_waitrequest;
            if (!wr) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
            t++;
            if (t > 200) begin
                chk({nm, "_accept_timeout"}, 512'(1), 512'(0));
                break;
            end
        end
    endtask

    task automatic wr_beat(input logic [26:0] a, input logic [6:0] bc, input logic [511:0] d,
                           input logic [63:0] be, input int line);
        int acc;
        bit ok;
        b_wr = 1'b1; b_rd = 1'b0; b_addr = a; b_bc = bc; b_wdata = d; b_be = be;
        wait_acc("write", acc, ok);
        if (ok) begin
            for (int i = 0; i < 64; i++)
                if (be[i]) mdl[b_sel][line][i*8 +: 8] = d[i*8 +: 8];
        end
        @(posedge clk); #1;
    endtask

    // Later beats drive junk address/burstcount, which the DUT must ignore.
    task automatic wr_burst(input int a, input int n, input int seed);
        for (int k = 0; k < n; k++)
            wr_beat((k == 0) ? 27'(a) : 27'h5A5, (k == 0) ? 7'(n) : 7'd99,
                    pat(seed + k), '1, (a + k) & 1023);
        b_wr = 1'b0;
    endtask

    task automatic rd_burst(input int a, input int n, input bit exact, output int acc);
        bit ok;
        int lat;
        lat = (b_sel == 1) ? L1 : L0;
        b_rd = 1'b1; b_wr = 1'b0; b_addr = 27'(a); b_bc = 7'(n);
        wait_acc("read", acc, ok);
        if (ok) begin
            for (int k = 0; k < n; k++) begin
                if (b_sel == 1) q1.push_back('{d: mdl[1][(a + k) & 1023], cyc: exact ? acc + lat + k : -1});
                else            q0.push_back('{d: mdl[0][(a + k) & 1023], cyc: exact ? acc + lat + k : -1});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        b_rd = 1'b0; b_wr = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", 512'(q0.size() + q1.size()), 512'(0));
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    int acc, acc_first, acc9;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_waitrequest", 512'(if0.DDR4_waitrequest), 512'(1));
        chk("reset_readdatavalid", 512'(if0.DDR4_readdatavalid), 512'(0));
        chk("reset_readdata", if0.DDR4_readdata, 512'(0));
        chk("reset_proto_err", 512'(perr0), 512'(0));
        chk("reset_rd_outstanding", 512'(out0), 512'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4-beat burst write then exact-latency readback.
        wr_beat(27'h20, 7'd1, {64{8'hAA}}, '1, 'h20);
        wr_burst('h10, 4, 100);
        rd_burst('h10, 4, 1'b1, acc);
        idle();
        drain();
        chk("burst_proto_err", 512'(perr0), 512'(0));
        chk("burst_rd_outstanding", 512'(out0), 512'(0));

        // Partial byte write over an 0xAA line.
        wr_beat(27'h20, 7'd1, pat(200), 64'h0000_0000_0000_00FF, 'h20);
        idle();
        rd_burst('h20, 1, 1'b1, acc);
        idle();
        drain();

        // Burst wrapping at the top of the RAM, plus an aliased address.
        wr_burst('h3FF, 3, 300);
        rd_burst('h3FF, 3, 1'b1, acc);
        idle();
        drain();
        rd_burst('h000, 1, 1'b1, acc);
        rd_burst('h400_0010, 1, 1'b0, acc);
        idle();
        drain();

        // Read/write collision: write taken, read dropped, proto_err sticky.
        b_rd = 1'b1; b_wr = 1'b1; b_addr = 27'h40; b_bc = 7'd1; b_wdata = pat(400); b_be = '1;
        @(negedge clk);
        chk("collision_waitrequest", 512'(if0.DDR4_waitrequest), 512'(0));
        mdl[0]['h40] = pat(400);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("collision_proto_err", 512'(perr0), 512'(1));
        chk("collision_read_dropped", 512'(out0), 512'(0));
        do_reset();
        @(negedge clk);
        chk("proto_err_cleared_by_reset", 512'(perr0), 512'(0));
        @(posedge clk); #1;
        wr_beat(27'h41, 7'd1, pat(500), '1, 'h41);
        wr_beat(27'h42, 7'd1, pat(501), '1, 'h42);
        wr_beat(27'h41, 7'd0, pat(600), '1, 'h41);
        idle();
        @(negedge clk);
        chk("bc0_proto_err", 512'(perr0), 512'(1));
        @(posedge clk); #1;
        rd_burst('h40, 3, 1'b1, acc);
        idle();
        drain();
        chk("proto_err_sticky", 512'(perr0), 512'(1));

        // Fill the read-command limit on the long-latency instance.
        b_sel = 1;
        wr_burst('h100, 9, 700);
        for (int i = 0; i < 8; i++) begin
            rd_burst('h100 + i, 1, 1'b1, acc);
            if (i == 0) acc_first = acc;
        end
        b_addr = 27'h108;
        @(negedge clk);
        chk("full_waitrequest", 512'(if1.DDR4_waitrequest), 512'(1));
        chk("full_rd_outstanding", 512'(out1), 512'(8));
        rd_burst('h108, 1, 1'b1, acc9);
        idle();
        chk("ninth_read_accept_cycle", 512'(acc9 - acc_first), 512'(17));
        drain();
        b_sel = 0;

        // Reset during the second beat of an 8-beat read burst.
        wr_burst('h80, 8, 800);
        rd_burst('h80, 8, 1'b1, acc);
        idle();
        while (cyc < acc + L0 + 1) @(negedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("midreset_readdatavalid", 512'(if0.DDR4_readdatavalid), 512'(0));
        chk("midreset_rd_outstanding", 512'(out0), 512'(0));
        chk("midreset_waitrequest", 512'(if0.DDR4_waitrequest), 512'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        @(posedge clk); #1;
        rd_burst('h80, 2, 1'b1, acc);
        rd_burst('h10, 1, 1'b0, acc);
        idle();
        drain();
        chk("final_rd_outstanding", 512'(out0), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
